// File: rtl/tc_to_sm_serial_pkg.sv
// Shared types and defaults for the two's-complement to sign-magnitude converter.
package tc_pkg;

  localparam int TC_WIDTH_DEF = 32;

  typedef enum logic [1:0] {TC_IDLE, TC_SHIFT, TC_DONE} tc_state_t;

endpackage

// File: rtl/tc_to_sm_serial_if.sv
// Input/output handshake bundle for tc_to_sm_serial.
// Macro TC2SM_MINNEG_FLAG_EN adds the out_minneg flag.
interface tc_to_sm_serial_if
  import tc_pkg::*;
#(
  parameter int WIDTH = TC_WIDTH_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic [WIDTH-1:0] out_mag;
`ifdef TC2SM_MINNEG_FLAG_EN
  logic             out_minneg;
`endif

  modport master (
`ifdef TC2SM_MINNEG_FLAG_EN
    input  out_minneg,
`endif
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sign,
    input  out_mag
  );

  modport slave (
`ifdef TC2SM_MINNEG_FLAG_EN
    output out_minneg,
`endif
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sign,
    output out_mag
  );

endinterface

// File: rtl/tc_to_sm_serial_neg_cell.sv
// One-bit serial negation cell: copy bits until the first 1 has passed, then invert.
module tc_serial_neg_cell (
  input  logic b,
  input  logic seen_one_i,
  output logic r,
  output logic seen_one_o
);

  assign r          = b ^ seen_one_i;
  assign seen_one_o = seen_one_i | b;

endmodule

// File: rtl/tc_to_sm_serial.sv
// Two's-complement to sign-magnitude converter; negative words are negated bit-serially, LSB first.
// Macro TC2SM_MINNEG_FLAG_EN enables the out_minneg flag.
module tc_to_sm_serial
  import tc_pkg::*;
#(
  parameter int WIDTH = TC_WIDTH_DEF
) (
  input logic              clk,
  input logic              rst_n,
  tc_to_sm_serial_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [1:0] S_IDLE  = TC_IDLE;
  localparam logic [1:0] S_SHIFT = TC_SHIFT;
  localparam logic [1:0] S_DONE  = TC_DONE;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_seen_one;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_mag;
  logic             r_sign;
  logic             r_minneg;

  logic             w_b;
  logic             w_r;
  logic             w_seen_nxt;
  logic             w_accept;

  assign w_b      = r_shift[0];
  assign w_accept = (r_state == S_IDLE) && bus.in_valid;

  tc_serial_neg_cell u_cell (
    .b          (w_b),
    .seen_one_i (r_seen_one),
    .r          (w_r),
    .seen_one_o (w_seen_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_seen_one <= 1'b0;
      r_mag      <= '0;
      r_sign     <= 1'b0;
      r_minneg   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (!bus.in_data[WIDTH-1]) begin
              r_mag    <= bus.in_data;
              r_sign   <= 1'b0;
              r_minneg <= 1'b0;
              r_state  <= S_DONE;
            end else begin
              r_cnt      <= '0;
              r_seen_one <= 1'b0;
              r_sign     <= 1'b1;
              r_minneg   <= (bus.in_data == MIN_NEG);
              r_state    <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          // Result bits enter at the MSB so bit 0 lands at position 0 after WIDTH shifts.
          r_mag      <= {w_r, r_mag[WIDTH-1:1]};
          r_seen_one <= w_seen_nxt;
          r_cnt      <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) r_state <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Operand shifter carries no reset: its content is only consumed after a fresh load.
  always_ff @(posedge clk) begin
    if (w_accept) r_shift <= bus.in_data;
    else if (r_state == S_SHIFT) r_shift <= {1'b0, r_shift[WIDTH-1:1]};
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.out_sign  = r_sign;
  assign bus.out_mag   = r_mag;
`ifdef TC2SM_MINNEG_FLAG_EN
  assign bus.out_minneg = r_minneg && (r_state == S_DONE);
`endif

endmodule

// File: tb/tb_tc_to_sm_serial.sv
// Randomized self-checking bench for tc_to_sm_serial against an arithmetic |x| model.
module tb_tc_to_sm_serial;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  tc_to_sm_serial_if #(.WIDTH(W)) bus ();

  tc_to_sm_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: sign is x<0, magnitude is |x| computed in wider signed arithmetic.
  function automatic logic [W:0] model(input logic [W-1:0] x);
    longint v;
    longint a;
    logic [63:0] au;
    v  = longint'($signed(x));
    a  = (v < 0) ? -v : v;
    au = a;
    return {(v < 0), au[W-1:0]};
  endfunction

  // Offers a word and returns once the accepting edge has passed.
  task automatic send_word(input logic [W-1:0] w, output bit ok);
    int guard;
    ok = 1'b1;
    @(negedge clk);
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) ok = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Counts accepting edge plus following edges until out_valid is seen at a negedge.
  task automatic wait_valid(output int lat, output bit ok);
    lat = 1;
    ok  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
      lat++;
    end
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_total++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    n_total++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_total++;
    if ({bus.out_sign, bus.out_mag} !== {1'b0, {W{1'b0}}})
      $display("FAIL reset_outputs: got sign %b mag %h want 0/0", bus.out_sign, bus.out_mag);
    else n_pass++;
`ifdef TC2SM_MINNEG_FLAG_EN
    n_total++;
    if (bus.out_minneg !== 1'b0) $display("FAIL reset_minneg: got %b want 0", bus.out_minneg); else n_pass++;
`endif
  endtask

  task automatic test_convert(input string name, input logic [W-1:0] w, input int exp_lat);
    bit ok;
    int lat;
    logic [W:0] e;
    e = model(w);
    send_word(w, ok);
    wait_valid(lat, ok);
    n_total++;
    if (!ok || lat != exp_lat) $display("FAIL %s_latency: got %0d (valid=%b) want %0d", name, lat, ok, exp_lat);
    else n_pass++;
    n_total++;
    if ({bus.out_sign, bus.out_mag} !== e)
      $display("FAIL %s_result: got sign %b mag %h want sign %b mag %h", name, bus.out_sign, bus.out_mag, e[W], e[W-1:0]);
    else n_pass++;
`ifdef TC2SM_MINNEG_FLAG_EN
    n_total++;
    if (bus.out_minneg !== (w == {1'b1, {(W-1){1'b0}}}))
      $display("FAIL %s_minneg: got %b want %b", name, bus.out_minneg, (w == {1'b1, {(W-1){1'b0}}}));
    else n_pass++;
`endif
    release_out();
  endtask

  task automatic test_stall();
    bit ok;
    int lat;
    logic [W-1:0] w;
    w = 32'hFFFF_FF00;
    send_word(w, ok);
    wait_valid(lat, ok);
    bus.in_data  = 32'h0000_0005;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n_total++;
      if (!(bus.out_valid === 1'b1 && bus.out_mag === 32'h0000_0100 && bus.out_sign === 1'b1 && bus.in_ready === 1'b0))
        $display("FAIL stall_hold[%0d]: got valid %b sign %b mag %h in_ready %b want 1/1/00000100/0",
                 i, bus.out_valid, bus.out_sign, bus.out_mag, bus.in_ready);
      else n_pass++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    release_out();
    @(negedge clk);
    n_total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL stall_release: got in_ready %b valid %b want 1/0", bus.in_ready, bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid_shift();
    bit ok;
    send_word(32'h8000_0001, ok);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_sign !== 1'b0 || bus.out_mag !== '0)
      $display("FAIL midshift_reset: got valid %b in_ready %b sign %b mag %h want 0/1/0/0",
               bus.out_valid, bus.in_ready, bus.out_sign, bus.out_mag);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    test_convert("after_reset", 32'hFFFF_FFFB, W + 1);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words[$];
    logic [W-1:0] expq[$];
    int got;
    bit drv_ok;
    words = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    for (int i = 0; i < 1000; i++) words.push_back(W'($urandom));
    got = 0;
    drv_ok = 1'b1;
    bus.out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < words.size(); i++) begin
          int guard;
          @(negedge clk);
          bus.in_data  = words[i];
          bus.in_valid = 1'b1;
          guard = 0;
          while (!bus.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
          end
          if (!bus.in_ready) drv_ok = 1'b0;
          @(posedge clk);
          expq.push_back(words[i]);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
      end
      begin
        int cyc;
        logic [W-1:0] w;
        logic [W:0] e;
        cyc = 0;
        while (got < words.size() && cyc < 60000) begin
          @(negedge clk);
          cyc++;
          if (bus.out_valid) begin
            n_total++;
            if (expq.size() == 0) begin
              $display("FAIL b2b_extra: got unexpected word mag %h want none", bus.out_mag);
            end else begin
              w = expq.pop_front();
              e = model(w);
              if ({bus.out_sign, bus.out_mag} !== e)
                $display("FAIL b2b_word[%0d]: in %h got sign %b mag %h want sign %b mag %h",
                         got, w, bus.out_sign, bus.out_mag, e[W], e[W-1:0]);
              else n_pass++;
            end
            got++;
          end
        end
      end
    join
    bus.out_ready = 1'b0;
    n_total++;
    if (got != words.size() || expq.size() != 0 || !drv_ok)
      $display("FAIL b2b_count: got %0d words, %0d pending, drv_ok %b want %0d/0/1", got, expq.size(), drv_ok, words.size());
    else n_pass++;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_reset_mid_shift();
    test_convert("pos5", 32'h0000_0005, 1);
    test_convert("neg5", 32'hFFFF_FFFB, W + 1);
    test_convert("minneg", 32'h8000_0000, W + 1);
    test_convert("zero", 32'h0000_0000, 1);
    test_convert("minus1", 32'hFFFF_FFFF, W + 1);
    bus.out_ready = 1'b1;
    test_convert("early_ready", 32'hFFFF_FF9C, W + 1);
    bus.out_ready = 1'b0;
    test_stall();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
